// File: rtl/line_reduction_sequencer.sv
// rtl/line_reduction_sequencer.sv - Bresenham line walker scoring per-pixel darkness reduction
// Issues one image read per pixel and accumulates the signed reduction a drawn line would give.
module line_reduction_sequencer #(
    parameter int COORD_W   = 10,
    parameter int IMG_W     = 640,
    parameter int ADDR_W    = 19,
    parameter int ACC_W     = 24,
    parameter int LINE_DARK = 150
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [COORD_W-1:0]      x0,
    input  logic [COORD_W-1:0]      y0,
    input  logic [COORD_W-1:0]      x1,
    input  logic [COORD_W-1:0]      y1,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd_en,
    input  logic [8:0]              mem_rdata,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic signed [ACC_W-1:0] score,
    output logic [COORD_W:0]        pixel_count,
    output logic                    busy
);

    localparam int EW = COORD_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WALK, S_DRAIN, S_DONE} state_t;

    state_t                  state;
    logic [COORD_W-1:0]      lx0, ly0, lx1, ly1;
    logic [COORD_W-1:0]      cx, cy;
    logic signed [EW-1:0]    dx, dy, err;
    logic                    sx_neg, sy_neg;
    logic                    rd_valid;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

    function automatic logic signed [10:0] pen(input logic signed [10:0] v);
        return v[10] ? ((-v) >>> 1) : v;
    endfunction

    logic signed [EW-1:0] adx, ady;
    always_comb begin
        adx = (lx1 >= lx0) ? EW'(lx1 - lx0) : EW'(lx0 - lx1);
        ady = (ly1 >= ly0) ? EW'(ly1 - ly0) : EW'(ly0 - ly1);
    end

    // Both axis steps are decided from the same e2, so a diagonal move happens in one cycle.
    logic signed [EW:0]   e2, dx_e, dy_e;
    logic signed [EW-1:0] err_nx;
    logic [COORD_W-1:0]   nx, ny;
    logic                 at_end;
    always_comb begin
        e2     = {err, 1'b0};
        dx_e   = (EW+1)'(dx);
        dy_e   = (EW+1)'(dy);
        err_nx = err;
        nx     = cx;
        ny     = cy;
        if (e2 >= dy_e) begin
            err_nx = err_nx + dy;
            nx     = sx_neg ? cx - COORD_W'(1) : cx + COORD_W'(1);
        end
        if (e2 <= dx_e) begin
            err_nx = err_nx + dx;
            ny     = sy_neg ? cy - COORD_W'(1) : cy + COORD_W'(1);
        end
        at_end = (cx == lx1) && (cy == ly1);
    end

    logic signed [10:0] p, q, red;
    always_comb begin
        p   = {{2{mem_rdata[8]}}, mem_rdata};
        q   = p - 11'(LINE_DARK);
        red = pen(p) - pen(q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            score        <= '0;
            pixel_count  <= '0;
            busy         <= 1'b0;
            lx0          <= '0;
            ly0          <= '0;
            lx1          <= '0;
            ly1          <= '0;
            cx           <= '0;
            cy           <= '0;
            dx           <= '0;
            dy           <= '0;
            err          <= '0;
            sx_neg       <= 1'b0;
            sy_neg       <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            // Read data lands the cycle after the strobe; accumulate it there.
            rd_valid <= mem_rd_en;
            if (rd_valid) begin
                score       <= score + ACC_W'(red);
                pixel_count <= pixel_count + (COORD_W+1)'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start_valid && start_ready) begin
                        lx0         <= x0;
                        ly0         <= y0;
                        lx1         <= x1;
                        ly1         <= y1;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    dx          <= adx;
                    dy          <= -ady;
                    err         <= adx - ady;
                    sx_neg      <= !(lx0 < lx1);
                    sy_neg      <= !(ly0 < ly1);
                    cx          <= lx0;
                    cy          <= ly0;
                    mem_addr    <= pix_addr(lx0, ly0);
                    mem_rd_en   <= 1'b1;
                    score       <= '0;
                    pixel_count <= '0;
                    state       <= S_WALK;
                end
                S_WALK: begin
                    if (at_end) begin
                        mem_rd_en <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        cx       <= nx;
                        cy       <= ny;
                        err      <= err_nx;
                        mem_addr <= pix_addr(nx, ny);
                    end
                end
                S_DRAIN: begin
                    result_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
